// File: rtl/rib_arbiter.sv
// rib_arbiter: two-master (JTAG, core) to four-slave bus sequencer.
// Arbitrates round-robin on ties, decodes the slave from addr[31:28], and
// completes every transaction with a one-cycle ack. A missing slave ack ends
// in a timeout error, and an unmapped address ends in a decode error.
//
// state | meaning
// IDLE  | sample m_req_i, grant a master, latch its command
// BUSY  | s_req_o held to the selected slave, waiting for its ack or timeout
// RESP  | one-cycle m_ack_o to the granted master with latched rdata/err
module rib_arbiter #(
  parameter int unsigned TIMEOUT = 16  // 2..255 BUSY cycles before error
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   m_req_i,
  input  logic         m0_we_i,
  input  logic         m1_we_i,
  input  logic [31:0]  m0_addr_i,
  input  logic [31:0]  m1_addr_i,
  input  logic [31:0]  m0_wdata_i,
  input  logic [31:0]  m1_wdata_i,
  output logic [1:0]   m_ack_o,
  output logic         m_err_o,
  output logic [31:0]  m_rdata_o,
  output logic [3:0]   s_req_o,
  output logic         s_we_o,
  output logic [31:0]  s_addr_o,
  output logic [31:0]  s_wdata_o,
  input  logic [3:0]   s_ack_i,
  input  logic [127:0] s_rdata_i,
  output logic         gnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        gnt_d, we_d, err_q, err_d;
  logic [31:0] addr_d, wdata_d, rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        win;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  sel;

  // Selected slave; only meaningful in BUSY, where addr[31:30] is known zero.
  assign sel = s_addr_o[29:28];

  // State and latched command/response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_o     <= 1'b1;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_o     <= gnt_d;
      s_we_o    <= we_d;
      s_addr_o  <= addr_d;
      s_wdata_o <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Arbitration, decode, ack/timeout handling and next state.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_o;
    we_d      = s_we_o;
    addr_d    = s_addr_o;
    wdata_d   = s_wdata_o;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    // On a tie the master that was not granted last wins.
    win       = (m_req_i == 2'b11) ? ~gnt_o : m_req_i[1];
    req_we    = win ? m1_we_i    : m0_we_i;
    req_addr  = win ? m1_addr_i  : m0_addr_i;
    req_wdata = win ? m1_wdata_i : m0_wdata_i;
    case (state_q)
      IDLE: begin
        if (m_req_i != 2'b00) begin
          gnt_d   = win;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (req_addr[31:30] == 2'b00) begin
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        // The ack is checked first so it wins over a same-cycle timeout.
        if (s_ack_i[sel]) begin
          rdata_d = s_rdata_i[{sel, 5'b00000} +: 32];
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes decoded from the current state.
  always_comb begin
    s_req_o   = (state_q == BUSY) ? (4'b0001 << sel) : 4'b0000;
    m_ack_o   = (state_q == RESP) ? (2'b01 << gnt_o) : 2'b00;
    m_err_o   = (state_q == RESP) & err_q;
    m_rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: scoreboard bench for rib_arbiter with a transaction-level
// model: expected responses are queued per master at issue, grants are
// predicted from the round-robin rule, and a monitor checks every ack.
module tb_rib_arbiter;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req    [2];
  logic         mwe    [2];
  logic [31:0]  maddr  [2];
  logic [31:0]  mwdata [2];
  logic [1:0]   m_req;
  logic [1:0]   m_ack;
  logic         m_err;
  logic [31:0]  m_rdata;
  logic [3:0]   s_req;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_ack;
  logic [127:0] s_rdata;
  logic         gnt;

  assign m_req = {req[1], req[0]};

  rib_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req_i(m_req),
    .m0_we_i(mwe[0]), .m1_we_i(mwe[1]),
    .m0_addr_i(maddr[0]), .m1_addr_i(maddr[1]),
    .m0_wdata_i(mwdata[0]), .m1_wdata_i(mwdata[1]),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_rdata_i(s_rdata), .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          busy;
  } exp_t;

  exp_t eq0[$];
  exp_t eq1[$];
  int   gq[$];
  int   gcyc[$];
  int   lat_m   [2] = '{0, 0};
  int   ack_cnt [2] = '{0, 0};
  int   cyc = 0;
  int   ref_last = 1;
  bit   ref_idle = 1'b1;
  bit   ref_resp = 1'b0;
  int   slv_n = 0;
  int   mon_busy = 0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [31:0] slave_word(int j, logic [31:0] a);
    logic [31:0] m;
    m = 32'(j + 1);
    return a ^ (m * 32'h9E37_79B9);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    total++;
    bad++;
    $display("FAIL %s: got nothing expected an event at t=%0t", nm, $time);
  endtask

  function automatic int exp_size(int m);
    return (m == 0) ? eq0.size() : eq1.size();
  endfunction

  function automatic exp_t exp_peek(int m);
    return (m == 0) ? eq0[0] : eq1[0];
  endfunction

  // Slave data: slice j is a fixed function of the latched address.
  always_comb begin
    s_rdata = '0;
    for (int j = 0; j < 4; j++) s_rdata[32*j +: 32] = slave_word(j, s_addr);
  end

  // Slave model: ack after the granted master's chosen latency (0 = never),
  // plus random stray acks on slaves that are not selected.
  initial begin
    logic [3:0] a;
    int sel, lat, j;
    s_ack = 4'b0000;
    forever begin
      @(negedge clk);
      a = 4'b0000;
      if (s_req != 4'b0000) begin
        slv_n++;
        sel = int'(s_addr[29:28]);
        lat = (gq.size() > 0) ? lat_m[gq[0]] : 0;
        if (lat != 0 && slv_n == lat) a[sel] = 1'b1;
        j = int'($urandom_range(3));
        if (j != sel && $urandom_range(2) == 0) a[j] = 1'b1;
      end else begin
        slv_n = 0;
        if ($urandom_range(3) == 0) a[$urandom_range(3)] = 1'b1;
      end
      s_ack = a;
    end
  end

  // Grant predictor: a free arbiter picks the single requester, or on a tie
  // the master not served last; it is free again one cycle after each ack.
  initial begin
    int w;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        ref_idle = 1'b1;
        ref_resp = 1'b0;
        ref_last = 1;
        gq.delete();
        gcyc.delete();
      end else begin
        cyc++;
        if (ref_resp) begin
          ref_resp = 1'b0;
          ref_idle = 1'b1;
        end else if (ref_idle && m_req != 2'b00) begin
          w = (m_req == 2'b11) ? 1 - ref_last : (m_req[1] ? 1 : 0);
          ref_last = w;
          ref_idle = 1'b0;
          gq.push_back(w);
          gcyc.push_back(cyc);
        end
      end
    end
  end

  // Monitor: checks slave-side strobes and pops the scoreboard on each ack.
  initial begin
    exp_t e;
    int m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_busy = 0;
      end else begin
        if (s_req != 4'b0000) begin
          mon_busy++;
          chk("s_req_onehot", 32'($onehot(s_req)), 32'd1);
          if (mon_busy == 1) begin
            if (gq.size() == 0 || exp_size(gq[0]) == 0) fail_now("s_req_unexpected");
            else begin
              e = exp_peek(gq[0]);
              chk("s_req_decode", 32'(s_req),
                  (e.addr[31:30] == 2'b00) ? 32'(4'b0001 << e.addr[29:28]) : 32'd0);
              chk("gnt_busy", 32'(gnt), 32'(gq[0]));
              chk("s_addr", s_addr, e.addr);
              chk("s_we", 32'(s_we), 32'(e.we));
              chk("s_wdata", s_wdata, e.wdata);
            end
          end
        end
        if (m_ack != 2'b00) begin
          chk("ack_onehot", 32'($onehot(m_ack)), 32'd1);
          chk("s_req_in_resp", 32'(s_req), 32'd0);
          m = m_ack[1] ? 1 : 0;
          if (gq.size() == 0) fail_now("ack_unpredicted");
          else begin
            chk("ack_master", 32'(m), 32'(gq[0]));
            chk("gnt_ack", 32'(gnt), 32'(gq[0]));
            if (exp_size(gq[0]) > 0) begin
              e = exp_peek(gq[0]);
              chk("ack_latency", 32'(cyc - gcyc[0]), 32'(e.busy));
            end
            void'(gq.pop_front());
            void'(gcyc.pop_front());
          end
          if (exp_size(m) == 0) fail_now("ack_no_expected");
          else begin
            e = (m == 0) ? eq0.pop_front() : eq1.pop_front();
            chk("ack_addr", s_addr, e.addr);
            chk("m_err", 32'(m_err), 32'(e.err));
            chk("m_rdata", m_rdata, e.rdata);
            chk("busy_cycles", 32'(mon_busy), 32'(e.busy));
          end
          mon_busy = 0;
          ack_cnt[m]++;
          ref_resp = 1'b1;
        end
      end
    end
  end

  task automatic issue(int i, logic [31:0] a, logic we, logic [31:0] wd, int lat);
    exp_t e;
    int k;
    k = int'(a[31:28]);
    e.addr  = a;
    e.we    = we;
    e.wdata = wd;
    if (k >= 4) begin
      e.err = 1'b1; e.rdata = '0; e.busy = 0;
    end else if (lat == 0 || lat > TO) begin
      e.err = 1'b1; e.rdata = '0; e.busy = TO;
    end else begin
      e.err = 1'b0; e.rdata = slave_word(k, a); e.busy = lat;
    end
    if (i == 0) eq0.push_back(e); else eq1.push_back(e);
    lat_m[i]  = lat;
    maddr[i]  = a;
    mwe[i]    = we;
    mwdata[i] = wd;
    req[i]    = 1'b1;
  endtask

  task automatic wait_ack(int i);
    int start;
    bit seen;
    start = ack_cnt[i];
    seen  = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (ack_cnt[i] != start) seen = 1'b1;
    end
    if (!seen) fail_now($sformatf("ack_timeout_m%0d", i));
  endtask

  task automatic rand_issue(int i, bit fast);
    logic [31:0] a;
    int r, lat;
    a = $urandom;
    r = int'($urandom_range(9));
    if (fast || r < 8) a[31:28] = 4'(r % 4);
    else a[31:28] = 4'($urandom_range(15, 4));
    r = int'($urandom_range(19));
    if (fast) lat = 1;
    else if (r < 13) lat = int'($urandom_range(4, 1));
    else if (r == 13) lat = 0;
    else if (r == 14) lat = TO - 1;
    else if (r == 15) lat = TO;
    else if (r == 16) lat = TO + 1;
    else lat = 1;
    issue(i, a, 1'($urandom_range(1)), $urandom, lat);
  endtask

  task automatic run_master(int i, int n, bit fast_hold);
    for (int t = 0; t < n; t++) begin
      rand_issue(i, fast_hold);
      wait_ack(i);
      if (t == n - 1 || !(fast_hold || $urandom_range(1) == 1)) begin
        req[i] = 1'b0;
        if (t < n - 1) begin
          repeat ($urandom_range(3)) @(negedge clk);
          #1;
        end
      end
    end
    req[i] = 1'b0;
  endtask

  initial begin
    int c1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = '0; mwdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_s_req", 32'(s_req), 32'd0);
    chk("rst_m_ack", 32'(m_ack), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_we", 32'(s_we), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    // Held tie straight after reset: JTAG, core, JTAG, core ...
    fork
      run_master(0, 4, 1'b1);
      run_master(1, 4, 1'b1);
    join
    repeat (2) @(negedge clk); #1;

    // Directed: single read, unmapped write, timeout, ack/timeout collision.
    issue(1, 32'h1000_0040, 1'b0, 32'h0, 2);           wait_ack(1); req[1] = 1'b0;
    issue(0, 32'h5000_0000, 1'b1, 32'h1234_5678, 1);   wait_ack(0); req[0] = 1'b0;
    issue(1, 32'h2000_0100, 1'b0, 32'h0, 0);           wait_ack(1); req[1] = 1'b0;
    issue(0, 32'h0000_0200, 1'b0, 32'h0, TO);          wait_ack(0); req[0] = 1'b0;
    issue(1, 32'h3000_0300, 1'b0, 32'h0, TO + 1);      wait_ack(1); req[1] = 1'b0;
    repeat (2) @(negedge clk); #1;

    // Random traffic from both masters.
    fork
      run_master(0, 30, 1'b0);
      run_master(1, 30, 1'b0);
    join
    repeat (3) @(negedge clk); #1;

    // Reset in the middle of a BUSY transaction.
    issue(1, 32'h2000_0400, 1'b0, 32'h0, 0);
    repeat (4) @(negedge clk); #1;
    chk("busy_before_rst", 32'(s_req), 32'h4);
    c1 = ack_cnt[1];
    rst = 1'b0;
    #1;
    chk("rst_mid_s_req", 32'(s_req), 32'd0);
    chk("rst_mid_m_ack", 32'(m_ack), 32'd0);
    chk("rst_mid_gnt", 32'(gnt), 32'd1);
    eq1.delete();
    req[1] = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("rst_mid_no_ack", 32'(ack_cnt[1]), 32'(c1));
    rst = 1'b1;
    issue(0, 32'h1000_0500, 1'b0, 32'h0, 1);
    issue(1, 32'h2000_0600, 1'b1, 32'hCAFE_F00D, 1);
    wait_ack(0);
    req[0] = 1'b0;
    chk("tie_after_rst_core_waits", 32'(ack_cnt[1]), 32'(c1));
    wait_ack(1);
    req[1] = 1'b0;
    repeat (3) @(negedge clk); #1;

    chk("scoreboard_drained", 32'(eq0.size() + eq1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
